// File: rtl/pkt_parity_chk.sv
// Streaming packet parity checker. It XORs every data bit of a multi-beat packet,
// reports the odd/even check against the expected bit and counts erroring packets.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for the first beat of a packet
// ACC   | first beat taken, accumulating until the last beat
// RES   | result presented on m_*, waiting for m_ready; input stalled
module pkt_parity_chk #(
    parameter int DATA_W = 32,
    parameter int BEAT_W = 8,
    parameter int ERR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_last,
    input  logic              s_exp,
    input  logic              sel,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              m_check,
    output logic              m_err,
    output logic [BEAT_W-1:0] m_beats,
    output logic [ERR_W-1:0]  err_cnt,
    input  logic              err_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RES  = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic              acc_q;
    logic              sel_q;
    logic [BEAT_W-1:0] beats_q;
    logic              check_q;
    logic              err_q;
    logic [BEAT_W-1:0] m_beats_q;
    logic [ERR_W-1:0]  err_cnt_q;

    logic              accept;
    logic              finish;
    logic              beat_par;
    logic              acc_nxt;
    logic              sel_eff;
    logic [BEAT_W-1:0] beats_nxt;
    logic              check_nxt;
    logic              err_nxt;

    assign accept   = s_valid & s_ready;
    assign finish   = accept & s_last;
    assign beat_par = ^s_data;

    // First beat seeds the accumulator and mode; later beats fold into them.
    always_comb begin
        acc_nxt   = beat_par;
        sel_eff   = sel;
        beats_nxt = BEAT_W'(1);
        if (state == ACC) begin
            acc_nxt = acc_q ^ beat_par;
            sel_eff = sel_q;
            if (beats_q != {BEAT_W{1'b1}}) begin
                beats_nxt = beats_q + BEAT_W'(1);
            end else begin
                beats_nxt = beats_q;
            end
        end
    end

    assign check_nxt = sel_eff ? acc_nxt : ~acc_nxt;
    assign err_nxt   = check_nxt ^ s_exp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = s_last ? RES : ACC;
                end
            end
            ACC: begin
                if (finish) begin
                    state_nxt = RES;
                end
            end
            RES: begin
                if (m_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= 1'b0;
            sel_q     <= 1'b0;
            beats_q   <= '0;
            check_q   <= 1'b0;
            err_q     <= 1'b0;
            m_beats_q <= '0;
        end else begin
            if (accept) begin
                acc_q   <= acc_nxt;
                sel_q   <= sel_eff;
                beats_q <= beats_nxt;
            end
            if (finish) begin
                check_q   <= check_nxt;
                err_q     <= err_nxt;
                m_beats_q <= beats_nxt;
            end
        end
    end

    // Counted on entry to RES, so a stalled result is only counted once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (err_clr) begin
            err_cnt_q <= '0;
        end else if (finish && err_nxt && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
    end

    always_comb begin
        s_ready = rst_n && (state != RES);
        m_valid = (state == RES);
        m_check = check_q;
        m_err   = err_q;
        m_beats = m_beats_q;
        err_cnt = err_cnt_q;
    end

endmodule

// File: tb/tb_pkt_parity_chk.sv
// Randomized bench for pkt_parity_chk: a default-sized instance and a narrow
// instance (BEAT_W=2, ERR_W=2) share stimulus and are checked against a packet model.
module tb_pkt_parity_chk;

    localparam int MAX_A = 65535;
    localparam int MAX_B = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        s_exp = 1'b0;
    logic        sel = 1'b0;
    logic        m_ready = 1'b0;
    logic        err_clr = 1'b0;

    logic        s_ready_a, m_valid_a, m_check_a, m_err_a;
    logic [7:0]  m_beats_a;
    logic [15:0] err_cnt_a;
    logic        s_ready_b, m_valid_b, m_check_b, m_err_b;
    logic [1:0]  m_beats_b;
    logic [1:0]  err_cnt_b;

    int n_tests = 0;
    int n_fail  = 0;
    int err_a   = 0;
    int err_b   = 0;

    always #5 clk = ~clk;

    pkt_parity_chk dut_a (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_a),
        .s_data(s_data), .s_last(s_last), .s_exp(s_exp), .sel(sel),
        .m_valid(m_valid_a), .m_ready(m_ready), .m_check(m_check_a), .m_err(m_err_a),
        .m_beats(m_beats_a), .err_cnt(err_cnt_a), .err_clr(err_clr)
    );

    pkt_parity_chk #(.DATA_W(32), .BEAT_W(2), .ERR_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b),
        .s_data(s_data), .s_last(s_last), .s_exp(s_exp), .sel(sel),
        .m_valid(m_valid_b), .m_ready(m_ready), .m_check(m_check_b), .m_err(m_err_b),
        .m_beats(m_beats_b), .err_cnt(err_cnt_b), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int sat_add(input int v, input int max);
        return (v >= max) ? max : v + 1;
    endfunction

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check_result(input string tag, input logic exp_chk, input logic exp_err,
                                input int nb);
        check({tag, "_valid_a"}, 32'(m_valid_a), 32'd1);
        check({tag, "_valid_b"}, 32'(m_valid_b), 32'd1);
        check({tag, "_check_a"}, 32'(m_check_a), 32'(exp_chk));
        check({tag, "_check_b"}, 32'(m_check_b), 32'(exp_chk));
        check({tag, "_err_a"},   32'(m_err_a),   32'(exp_err));
        check({tag, "_err_b"},   32'(m_err_b),   32'(exp_err));
        check({tag, "_beats_a"}, 32'(m_beats_a), 32'(imin(nb, 255)));
        check({tag, "_beats_b"}, 32'(m_beats_b), 32'(imin(nb, MAX_B)));
        check({tag, "_ecnt_a"},  32'(err_cnt_a), 32'(err_a));
        check({tag, "_ecnt_b"},  32'(err_cnt_b), 32'(err_b));
        check({tag, "_sready"},  32'({s_ready_a, s_ready_b}), 32'd0);
    endtask

    // Sends one packet (directed data if dq is non-empty), then holds the result
    // for 'stall' cycles before accepting it.
    task automatic run_pkt(input string tag, input logic [31:0] dq[$], input int nb_in,
                           input logic sel0, input logic expv, input int stall,
                           input logic clr);
        logic        par;
        logic        exp_chk;
        logic        exp_err;
        logic [31:0] d;
        int          nb;
        int          g;
        nb  = (dq.size() > 0) ? dq.size() : nb_in;
        par = 1'b0;
        m_ready = 1'b0;
        for (int i = 0; i < nb; i++) begin
            @(negedge clk);
            if (i > 0 && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                s_data  = $urandom;
                s_last  = 1'b1;
                @(negedge clk);
            end
            g = 0;
            while (!s_ready_a && g < 50) begin
                @(negedge clk);
                g++;
            end
            if (!s_ready_a) check({tag, "_ready_timeout"}, 32'd0, 32'd1);
            d       = (dq.size() > 0) ? dq[i] : $urandom;
            s_valid = 1'b1;
            s_data  = d;
            s_last  = (i == nb - 1);
            sel     = (i == 0) ? sel0 : 1'($urandom_range(0, 1));
            s_exp   = (i == nb - 1) ? expv : 1'($urandom_range(0, 1));
            err_clr = (i == nb - 1) ? clr : 1'b0;
            if (($countones(d) % 2) == 1) par = ~par;
        end
        @(negedge clk);
        s_valid = 1'b0;
        err_clr = 1'b0;
        exp_chk = sel0 ? par : ~par;
        exp_err = (exp_chk != expv);
        if (clr) begin
            err_a = 0;
            err_b = 0;
        end else if (exp_err) begin
            err_a = sat_add(err_a, MAX_A);
            err_b = sat_add(err_b, MAX_B);
        end
        check_result(tag, exp_chk, exp_err, nb);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check_result({tag, "_hold"}, exp_chk, exp_err, nb);
        end
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check({tag, "_done_valid"}, 32'({m_valid_a, m_valid_b}), 32'd0);
        check({tag, "_done_ready"}, 32'({s_ready_a, s_ready_b}), 32'd3);
        check({tag, "_done_keep"},  32'({m_check_a, m_err_a}), 32'({exp_chk, exp_err}));
    endtask

    task automatic run_tput(input int npkt);
        logic [31:0] d;
        logic        sv, ev, ck, er;
        m_ready = 1'b1;
        for (int p = 0; p < npkt; p++) begin
            @(negedge clk);
            check("tput_ready", 32'({s_ready_a, s_ready_b}), 32'd3);
            d  = $urandom;
            sv = 1'($urandom_range(0, 1));
            ev = 1'($urandom_range(0, 1));
            s_valid = 1'b1;
            s_data  = d;
            s_last  = 1'b1;
            sel     = sv;
            s_exp   = ev;
            ck = sv ? 1'(($countones(d) % 2) == 1) : 1'(($countones(d) % 2) == 0);
            er = (ck != ev);
            if (er) begin
                err_a = sat_add(err_a, MAX_A);
                err_b = sat_add(err_b, MAX_B);
            end
            @(negedge clk);
            check_result("tput", ck, er, 1);
        end
        s_valid = 1'b0;
        @(negedge clk);
        m_ready = 1'b0;
        check("tput_end_valid", 32'({m_valid_a, m_valid_b}), 32'd0);
    endtask

    initial begin
        logic [31:0] q[$];
        #1;
        check("rst_sready",  32'({s_ready_a, s_ready_b}), 32'd0);
        check("rst_mvalid",  32'({m_valid_a, m_valid_b}), 32'd0);
        check("rst_outs_a",  32'({m_check_a, m_err_a, m_beats_a}), 32'd0);
        check("rst_outs_b",  32'({m_check_b, m_err_b, m_beats_b}), 32'd0);
        check("rst_ecnt",    32'({err_cnt_a, err_cnt_b}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_sready", 32'({s_ready_a, s_ready_b}), 32'd3);

        q = '{32'h0000_0007};
        run_pkt("single_sel1", q, 0, 1'b1, 1'b1, 0, 1'b0);
        run_pkt("single_sel0", q, 0, 1'b0, 1'b1, 0, 1'b0);
        q = '{32'h1, 32'h3, 32'hF};
        run_pkt("multi3", q, 0, 1'b1, 1'b1, 0, 1'b0);
        run_pkt("multi3_stall", q, 0, 1'b1, 1'b0, 5, 1'b0);
        q = {};
        run_pkt("beats6", q, 6, 1'b1, 1'b0, 1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            q = '{32'h0};
            run_pkt("err_sat", q, 0, 1'b1, 1'b1, 0, 1'b0);
        end
        q = '{32'h0};
        run_pkt("clr_coinc", q, 0, 1'b1, 1'b1, 0, 1'b1);
        run_pkt("err_after_clr", q, 0, 1'b1, 1'b1, 0, 1'b0);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        err_a = 0;
        err_b = 0;
        check("clr_alone", 32'({err_cnt_a, err_cnt_b}), 32'd0);

        q = {};
        for (int i = 0; i < 30; i++) begin
            run_pkt("rand", q, $urandom_range(1, 9), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'b0);
        end
        run_tput(8);

        // reset between beats 2 and 3
        @(negedge clk);
        s_valid = 1'b1; s_data = $urandom; s_last = 1'b0; sel = 1'b1;
        @(negedge clk);
        s_data = $urandom;
        @(negedge clk);
        s_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        err_a = 0;
        err_b = 0;
        check("rstmid_valid", 32'({m_valid_a, m_valid_b}), 32'd0);
        check("rstmid_sready", 32'({s_ready_a, s_ready_b}), 32'd0);
        check("rstmid_ecnt", 32'({err_cnt_a, err_cnt_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rstmid_noresult", 32'({m_valid_a, m_valid_b}), 32'd0);
        end
        q = '{32'h0};
        run_pkt("post_rst", q, 0, 1'b0, 1'b1, 0, 1'b0);

        // reset while the result is pending
        @(negedge clk);
        s_valid = 1'b1; s_data = 32'h1; s_last = 1'b1; sel = 1'b1; s_exp = 1'b0;
        @(negedge clk);
        s_valid = 1'b0;
        check("rstres_pre", 32'({m_valid_a, m_check_a, err_cnt_a}), 32'h30001);
        rst_n = 1'b0;
        #1;
        check("rstres_valid", 32'({m_valid_a, m_valid_b}), 32'd0);
        check("rstres_outs", 32'({m_check_a, m_err_a, m_beats_a, err_cnt_a}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstres_idle", 32'({m_valid_a, s_ready_a}), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
